// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the RV32I pipeline.
// Issues one data-memory request per load/store, holds it until dmem_resp,
// stalls the upstream pipeline meanwhile, formats load data and builds store
// byte enables. Optional response watchdog via RESP_TIMEOUT (0 = disabled).
// Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of issuing
// them with the offending low address bits cleared.
module mem_stage_lsu #(
  parameter int unsigned RESP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        ld_valid_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [31:0] TMO_LAST = (RESP_TIMEOUT == 0) ? 32'd0 : 32'(RESP_TIMEOUT - 1);

  state_t      state;
  logic [31:0] wd_cnt;
  logic        op_load;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_lane;

  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic [31:0] eff_addr;
  logic        start;
  logic        expire;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_fmt;

  // funct3[1:0]: 00 byte, 01 half, 1x word (covers 011/110/111)
  assign is_half = (funct3_i[1:0] == 2'b01);
  assign is_word = funct3_i[1];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (is_word & (addr_i[1:0] != 2'b00)) | (is_half & addr_i[0]);
  assign eff_addr   = addr_i;
  assign misalign_o = (state == IDLE) & valid_i & (mem_read_i | mem_write_i) & misaligned;
`else
  assign misaligned = 1'b0;
  assign eff_addr   = {addr_i[31:2], (is_word ? 2'b00 : {addr_i[1], addr_i[0] & ~is_half})};
  assign misalign_o = 1'b0;
`endif

  assign start   = (state == IDLE) & valid_i & (mem_read_i | mem_write_i) & ~misaligned;
  assign stall_o = start | (state == BUSY);
  assign expire  = (RESP_TIMEOUT != 0) && (wd_cnt == TMO_LAST);

  // Store lane mask and lane-replicated write data
  always_comb begin
    st_mask  = 4'b1111;
    st_wdata = store_data_i;
    if (funct3_i[1:0] == 2'b00) begin
      st_mask  = 4'b0001 << eff_addr[1:0];
      st_wdata = {4{store_data_i[7:0]}};
    end else if (is_half) begin
      st_mask  = 4'b0011 << {eff_addr[1], 1'b0};
      st_wdata = {2{store_data_i[15:0]}};
    end
  end

  // Load lane extraction and sign/zero extension using the latched op
  always_comb begin
    rd_shift = dmem_rdata >> {lat_lane, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = lat_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_f3[1:0])
      2'b00:   ld_fmt = {{24{~lat_f3[2] & rd_byte[7]}}, rd_byte};
      2'b01:   ld_fmt = {{16{~lat_f3[2] & rd_half[15]}}, rd_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  // Access FSM with registered request, result and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '1;
      load_data_o      <= '0;
      ld_valid_o       <= 1'b0;
      timeout_o        <= 1'b0;
      wd_cnt           <= '0;
      op_load          <= 1'b0;
      lat_f3           <= '0;
      lat_lane         <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state            <= BUSY;
            dmem_read        <= mem_read_i & ~mem_write_i;
            dmem_write       <= mem_write_i;
            dmem_address     <= {eff_addr[31:2], 2'b00};
            dmem_wdata       <= st_wdata;
            dmem_byte_enable <= mem_write_i ? st_mask : 4'b1111;
            op_load          <= ~mem_write_i;
            lat_f3           <= funct3_i;
            lat_lane         <= eff_addr[1:0];
            wd_cnt           <= '0;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            load_data_o <= ld_fmt;
            ld_valid_o  <= op_load;
            state       <= DONE;
          end else if (expire) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            timeout_o  <= 1'b1;
            state      <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        DONE: begin
          ld_valid_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (watchdog configured to 4).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i, dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata, load_data_o;
  logic [3:0]  dmem_byte_enable;
  logic        stall_o, ld_valid_o, misalign_o, timeout_o;

  int n_cmp = 0;
  int n_fail = 0;

  // Observations from the last run_op call
  int          o_stalls, o_busy;
  logic        o_done, o_rd, o_wr, o_ldv, o_tmo, o_tmo_after;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_be;

  mem_stage_lsu #(.RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall_o(stall_o), .load_data_o(load_data_o),
    .ld_valid_o(ld_valid_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Present one op, answer after resp_after idle BUSY cycles (-1 = never), record what happened
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int resp_after, input logic [31:0] rdata);
    o_stalls = 0; o_busy = 0; o_done = 1'b0; o_rd = 1'b0; o_wr = 1'b0;
    o_ldv = 1'b0; o_tmo = 1'b0; o_addr = '0; o_wdata = '0; o_be = '0; o_ld = '0;
    @(negedge clk);
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    addr_i = a; store_data_i = d; dmem_rdata = rdata; dmem_resp = 1'b0;
    for (int cyc = 0; cyc < 40 && !o_done; cyc++) begin
      #1;
      if (stall_o) o_stalls++;
      if (dmem_read || dmem_write) begin
        o_busy++;
        o_addr = dmem_address; o_wdata = dmem_wdata; o_be = dmem_byte_enable;
        o_rd = dmem_read; o_wr = dmem_write;
        dmem_resp = (o_busy == resp_after + 1);
      end else if (o_busy > 0) begin
        o_done = 1'b1; o_ldv = ld_valid_o; o_ld = load_data_o; o_tmo = timeout_o;
        dmem_resp = 1'b0;
      end else begin
        dmem_resp = 1'b0;
      end
      if (!o_done) @(negedge clk);
    end
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; dmem_resp = 1'b0;
    @(negedge clk);
    #1 o_tmo_after = timeout_o;
    n_cmp++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL op_completes: got %b want 1 (addr %h)", o_done, a); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = '0; addr_i = '0; store_data_i = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({dmem_read, dmem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_req: got %b want 00", {dmem_read, dmem_write}); end
    n_cmp++; if (dmem_byte_enable !== 4'b1111) begin n_fail++; $display("FAIL reset_be: got %b want 1111", dmem_byte_enable); end
    n_cmp++; if ({stall_o, ld_valid_o, misalign_o, timeout_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {stall_o, ld_valid_o, misalign_o, timeout_o}); end
    n_cmp++; if ({dmem_address, dmem_wdata, load_data_o} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want zeros", dmem_address, dmem_wdata, load_data_o); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_lw();
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    n_cmp++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h want 00000100", o_addr); end
    n_cmp++; if ({o_rd, o_wr, o_be} !== 6'b10_1111) begin n_fail++; $display("FAIL lw_req: got %b want 101111", {o_rd, o_wr, o_be}); end
    n_cmp++; if (o_stalls !== 4) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 4", o_stalls); end
    n_cmp++; if (o_busy !== 3) begin n_fail++; $display("FAIL lw_busy_cycles: got %0d want 3", o_busy); end
    n_cmp++; if ({o_ldv, o_ld} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL lw_data: got %b %h want 1 deadbeef", o_ldv, o_ld); end
    n_cmp++; if (ld_valid_o !== 1'b0) begin n_fail++; $display("FAIL lw_ldv_drop: got %b want 0", ld_valid_o); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b110};
    logic [31:0] ad [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h108};
    logic [31:0] rd [6] = '{32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233, 32'h89ABCDEF};
    logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011, 32'h00000022, 32'h89ABCDEF};
    for (int i = 0; i < 6; i++) begin
      run_op(1'b1, 1'b0, f3[i], ad[i], 32'h0, 0, rd[i]);
      n_cmp++; if ({o_ldv, o_ld} !== {1'b1, ex[i]}) begin n_fail++; $display("FAIL load_fmt[%0d]: got %b %h want 1 %h", i, o_ldv, o_ld, ex[i]); end
      n_cmp++; if (o_addr !== {ad[i][31:2], 2'b00}) begin n_fail++; $display("FAIL load_addr[%0d]: got %h want %h", i, o_addr, {ad[i][31:2], 2'b00}); end
      n_cmp++; if (o_stalls !== 2) begin n_fail++; $display("FAIL load_stall[%0d]: got %0d want 2", i, o_stalls); end
    end
  endtask

  task automatic test_store();
    logic        rd [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3 [4] = '{3'b001, 3'b000, 3'b010, 3'b010};
    logic [31:0] ad [4] = '{32'h202, 32'h201, 32'h300, 32'h304};
    logic [31:0] dt [4] = '{32'h0000ABCD, 32'h1234565A, 32'h12345678, 32'hCAFEF00D};
    logic [3:0]  be [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1111};
    logic [31:0] wd [4] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h12345678, 32'hCAFEF00D};
    for (int i = 0; i < 4; i++) begin
      run_op(rd[i], 1'b1, f3[i], ad[i], dt[i], 1, 32'hFFFFFFFF);
      n_cmp++; if (o_be !== be[i]) begin n_fail++; $display("FAIL store_be[%0d]: got %b want %b", i, o_be, be[i]); end
      n_cmp++; if (o_wdata !== wd[i]) begin n_fail++; $display("FAIL store_wdata[%0d]: got %h want %h", i, o_wdata, wd[i]); end
      n_cmp++; if ({o_rd, o_wr, o_ldv} !== 3'b010) begin n_fail++; $display("FAIL store_ctl[%0d]: got %b want 010", i, {o_rd, o_wr, o_ldv}); end
      n_cmp++; if (o_addr !== {ad[i][31:2], 2'b00}) begin n_fail++; $display("FAIL store_addr[%0d]: got %h want %h", i, o_addr, {ad[i][31:2], 2'b00}); end
    end
  endtask

  task automatic test_no_op();
    @(negedge clk);
    valid_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h40;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL noop_stall: got %b want 0", stall_o); end
    @(negedge clk);
    valid_i = 1'b0; mem_read_i = 1'b1;
    #1;
    n_cmp++; if ({dmem_read, dmem_write, stall_o} !== 3'b000) begin n_fail++; $display("FAIL noop_req: got %b want 000", {dmem_read, dmem_write, stall_o}); end
    @(negedge clk);
    #1;
    n_cmp++; if ({dmem_read, dmem_write} !== 2'b00) begin n_fail++; $display("FAIL invalid_req: got %b want 00", {dmem_read, dmem_write}); end
    mem_read_i = 1'b0;
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h101;
    #1;
    n_cmp++; if ({misalign_o, stall_o} !== 2'b10) begin n_fail++; $display("FAIL misalign_flag: got %b want 10", {misalign_o, stall_o}); end
    @(negedge clk);
    #1;
    n_cmp++; if ({dmem_read, dmem_write} !== 2'b00) begin n_fail++; $display("FAIL misalign_noreq: got %b want 00", {dmem_read, dmem_write}); end
    valid_i = 1'b0; mem_read_i = 1'b0;
`else
    run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h11223344);
    n_cmp++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL misalign_addr: got %h want 00000100", o_addr); end
    n_cmp++; if ({o_ldv, o_ld} !== {1'b1, 32'h11223344}) begin n_fail++; $display("FAIL misalign_data: got %b %h want 1 11223344", o_ldv, o_ld); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_tied: got %b want 0", misalign_o); end
`endif
  endtask

  task automatic test_timeout();
    run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h0);
    n_cmp++; if (o_busy !== 4) begin n_fail++; $display("FAIL tmo_busy: got %0d want 4", o_busy); end
    n_cmp++; if ({o_tmo, o_ldv} !== 2'b10) begin n_fail++; $display("FAIL tmo_pulse: got %b want 10", {o_tmo, o_ldv}); end
    n_cmp++; if (o_tmo_after !== 1'b0) begin n_fail++; $display("FAIL tmo_one_cycle: got %b want 0", o_tmo_after); end
    run_op(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 3, 32'h0BADF00D);
    n_cmp++; if ({o_tmo, o_ldv, o_ld} !== {2'b01, 32'h0BADF00D}) begin n_fail++; $display("FAIL tmo_resp_wins: got %b %h want 01 0badf00d", {o_tmo, o_ldv}, o_ld); end
    run_op(1'b1, 1'b0, 3'b010, 32'h408, 32'h0, 0, 32'h00C0FFEE);
    n_cmp++; if ({o_tmo, o_ldv, o_ld} !== {2'b01, 32'h00C0FFEE}) begin n_fail++; $display("FAIL tmo_next_op: got %b %h want 01 00c0ffee", {o_tmo, o_ldv}, o_ld); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h500;
    dmem_rdata = 32'h55555555;
    @(negedge clk);
    #1;
    n_cmp++; if (dmem_read !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 1", dmem_read); end
    rst_n = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0;
    #1;
    n_cmp++; if ({dmem_read, stall_o} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_drop: got %b want 00", {dmem_read, stall_o}); end
    @(negedge clk);
    rst_n = 1'b1; dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    n_cmp++; if ({ld_valid_o, dmem_read, stall_o} !== 3'b000) begin n_fail++; $display("FAIL rst_late_resp: got %b want 000", {ld_valid_o, dmem_read, stall_o}); end
    @(negedge clk);
    #1;
    n_cmp++; if (ld_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_late_ldv: got %b want 0", ld_valid_o); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_no_op();
    test_misalign();
    test_timeout();
    test_reset_mid_access();
    test_lw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, still running");
    $fatal(1, "time limit");
  end

endmodule
